seg_scan_decoder: RTL and testbench

Loopback decoder for the multiplexed seven-segment display bus produced by the board's counter-to-hex display driver. It samples the active-low anode and segment lines, waits for each digit dwell to settle, and decodes the segment pattern back to a hex nibble. It then reassembles the two 16-bit values shown on the eight digits. It sits beside the display driver in the top level, or in the bench, to check on-chip what the display actually shows.

---
 rtl/seg_scan_pkg.sv | 28 ++
 rtl/seg_scan_onehot.sv | 23 ++
 rtl/seg_scan_decoder.sv | 136 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and the seven-segment hex table for the display loopback decoder.
// seg2nib maps an active-low {G..A} pattern to {err, nibble}; unknown codes give err=1, nibble=0.
package seg_scan_pkg;

    typedef enum logic {
        S_WAIT,
        S_HELD
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [4:0] seg2nib(input logic [6:0] seg);
        logic [4:0] r;
        r = {1'b1, 4'h0};
        for (int i = 0; i < 16; i++) begin
            if (seg == HEX_SEG[i]) begin
                r = {1'b0, 4'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_onehot.sv
// Checks that exactly one active-low anode is lit and returns its position.
// Kept standalone so the display driver's assertions can reuse the same check.
module seg_scan_onehot (
    input  logic [7:0] i_an,
    output logic       o_onehot_ok,
    output logic [2:0] o_idx
);

    logic [7:0] w_low;

    assign w_low       = ~i_an;
    assign o_onehot_ok = (w_low != 8'h00) && ((w_low & (w_low - 8'h01)) == 8'h00);

    always_comb begin
        o_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_low[i]) begin
                o_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples the multiplexed active-low display bus, waits for each digit dwell to settle,
// decodes it, and publishes the two 16-bit values once all eight digits have been seen.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int DIGITS        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIGITS-1:0] an_i,
    input  logic [6:0]        seg_i,
    input  logic              dp_i,
    output logic [15:0]       val_1_o,
    output logic [15:0]       val_2_o,
    output logic              frame_valid_o,
    output logic              frame_err_o
);

    localparam int            CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TERM = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYCLES);

    logic [DIGITS-1:0]      r_an_q1, r_an_q, r_an_prev;
    logic [6:0]             r_seg_q1, r_seg_q;
    state_t                 r_state, w_state_n;
    logic [CW-1:0]          r_stab_cnt, w_cnt_n;
    logic [DIGITS-1:0]      r_seen, r_err_sh;
    logic [DIGITS-1:0][3:0] r_nib_sh;

    logic       w_an_chg;
    logic       w_capture;
    logic       w_onehot_ok;
    logic [2:0] w_idx;
    logic [4:0] w_dec;
    logic       w_unused_dp;

    // The decimal point carries no digit information.
    assign w_unused_dp = dp_i;

    seg_scan_onehot u_onehot (
        .i_an        (r_an_q),
        .o_onehot_ok (w_onehot_ok),
        .o_idx       (w_idx)
    );

    assign w_an_chg = (r_an_q != r_an_prev);
    assign w_dec    = seg2nib(r_seg_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_q1   <= '1;
            r_an_q    <= '1;
            r_an_prev <= '1;
            r_seg_q1  <= SEG_BLANK;
            r_seg_q   <= SEG_BLANK;
        end else begin
            r_an_q1   <= an_i;
            r_an_q    <= r_an_q1;
            r_an_prev <= r_an_q;
            r_seg_q1  <= seg_i;
            r_seg_q   <= r_seg_q1;
        end
    end

    // A change of the anode pattern always beats the terminal count.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_stab_cnt;
        w_capture = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_an_chg) begin
                    w_cnt_n = '0;
                end else begin
                    if ((r_stab_cnt == CNT_TERM) && w_onehot_ok) begin
                        w_capture = 1'b1;
                        w_state_n = S_HELD;
                    end
                    if (r_stab_cnt != CNT_MAX) begin
                        w_cnt_n = r_stab_cnt + CW'(1);
                    end
                end
            end
            S_HELD: begin
                if (w_an_chg) begin
                    w_state_n = S_WAIT;
                    w_cnt_n   = '0;
                end
            end
            default: begin
                w_state_n = S_WAIT;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_WAIT;
            r_stab_cnt <= '0;
        end else begin
            r_state    <= w_state_n;
            r_stab_cnt <= w_cnt_n;
        end
    end

    // A capture on the frame-clear cycle lands after the clear, so it is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen        <= '0;
            r_err_sh      <= '0;
            r_nib_sh      <= '0;
            val_1_o       <= '0;
            val_2_o       <= '0;
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            frame_valid_o <= 1'b0;
            if (r_seen == '1) begin
                val_1_o       <= r_nib_sh[3:0];
                val_2_o       <= r_nib_sh[7:4];
                frame_err_o   <= |r_err_sh;
                frame_valid_o <= 1'b1;
                r_seen        <= '0;
                r_err_sh      <= '0;
            end
            if (w_capture) begin
                r_seen[w_idx]   <= 1'b1;
                r_err_sh[w_idx] <= w_dec[4];
                r_nib_sh[w_idx] <= w_dec[3:0];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Drives display scans with long, short and faulty dwells and compares every published
// frame against a digit-level model of what the display showed.
module tb_seg_scan_decoder;

    localparam int SETTLE = 16;
    localparam int LONG_MIN = SETTLE + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  an_i;
    logic [6:0]  seg_i;
    logic        dp_i;
    logic [15:0] val_1_o, val_2_o;
    logic        frame_valid_o, frame_err_o;

    int checks = 0;
    int failures = 0;

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];

    logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0]  m_nib [8];
    logic [7:0]  m_err;
    logic [7:0]  m_seen;
    logic [32:0] m_last;
    bit          m_have;
    bit          prev_fv;

    seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .DIGITS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .an_i          (an_i),
        .seg_i         (seg_i),
        .dp_i          (dp_i),
        .val_1_o       (val_1_o),
        .val_2_o       (val_2_o),
        .frame_valid_o (frame_valid_o),
        .frame_err_o   (frame_err_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- frame monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_fv = 1'b0;
        end else begin
            if (frame_valid_o) begin
                obs_q.push_back({frame_err_o, val_2_o, val_1_o});
                checks++;
                if (prev_fv) begin
                    failures++;
                    $display("FAIL pulse_width frame_valid_o high on consecutive cycles got=1 want=0");
                end
            end
            prev_fv = frame_valid_o;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int n = 0; n < 16; n++) begin
            if (tbl[n] == s) return {1'b0, 4'(n)};
        end
        return 5'h10;
    endfunction

    task automatic m_clear();
        m_seen = 8'h00;
        m_err  = 8'h00;
        for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
    endtask

    task automatic m_capture(input int idx, input logic [6:0] s);
        logic [4:0] d;
        d = ref_decode(s);
        m_nib[idx]  = d[3:0];
        m_err[idx]  = d[4];
        m_seen[idx] = 1'b1;
        if (m_seen == 8'hFF) begin
            m_last = {|m_err, m_nib[7], m_nib[6], m_nib[5], m_nib[4],
                      m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
            m_have = 1'b1;
            exp_q.push_back(m_last);
            m_seen = 8'h00;
            m_err  = 8'h00;
        end
    endtask

    // ---------------- drivers ----------------
    // Blank gap, then one lit digit; long dwells are captured, short ones (<= SETTLE-6) never.
    task automatic show(input int idx, input logic [6:0] s, input int dwell);
        an_i  = 8'hFF;
        seg_i = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        an_i  = ~(8'h01 << idx);
        seg_i = s;
        dp_i  = 1'($urandom_range(0, 1));
        repeat (dwell) @(posedge clk);
        #1;
        if (dwell >= LONG_MIN) m_capture(idx, s);
    endtask

    task automatic drain();
        an_i  = 8'hFF;
        seg_i = 7'h7F;
        repeat (30) @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] rand_seg();
        if ($urandom_range(0, 99) < 85) return tbl[$urandom_range(0, 15)];
        return 7'($urandom);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b1;
        an_i  = 8'hFF;
        seg_i = 7'h7F;
        dp_i  = 1'b1;
        m_clear();
        m_have = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (val_1_o !== 16'h0) begin failures++; $display("FAIL reset val_1_o got=%h want=0000", val_1_o); end
        if (val_2_o !== 16'h0) begin failures++; $display("FAIL reset val_2_o got=%h want=0000", val_2_o); end
        if (frame_valid_o !== 1'b0) begin failures++; $display("FAIL reset frame_valid_o got=%b want=0", frame_valid_o); end
        if (frame_err_o !== 1'b0) begin failures++; $display("FAIL reset frame_err_o got=%b want=0", frame_err_o); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_scan();
        logic [3:0]  digs [8] = '{4'hB, 4'hA, 4'h4, 4'h3, 4'hE, 4'hF, 4'h2, 4'h1};
        logic [32:0] o, e;
        for (int i = 0; i < 8; i++) show(i, tbl[digs[i]], 1000);
        drain();
        checks++;
        if (obs_q.size() != 1) begin failures++; $display("FAIL basic frame_count got=%0d want=1", obs_q.size()); end
        checks += 3;
        if (val_1_o !== 16'h34AB) begin failures++; $display("FAIL basic val_1_o got=%h want=34ab", val_1_o); end
        if (val_2_o !== 16'h12FE) begin failures++; $display("FAIL basic val_2_o got=%h want=12fe", val_2_o); end
        if (frame_err_o !== 1'b0) begin failures++; $display("FAIL basic frame_err_o got=%b want=0", frame_err_o); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL basic frame got=%h want=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_short_dwell();
        logic [32:0] o, e;
        for (int i = 0; i < 8; i++) show(i, tbl[(i * 3 + 1) % 16], (i == 5) ? 10 : 24);
        drain();
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL short_dwell early_frames got=%0d want=0", obs_q.size()); end
        obs_q.delete();
        show(5, tbl[4'h7], 24);
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL short_dwell frame_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL short_dwell frame got=%h want=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_blank_err();
        logic [32:0] o, e;
        for (int i = 0; i < 8; i++) show(i, (i == 2) ? 7'h7F : tbl[4'h9 - 4'(i)], 30);
        drain();
        checks += 2;
        if (frame_err_o !== 1'b1) begin failures++; $display("FAIL blank_err frame_err_o got=%b want=1", frame_err_o); end
        if (val_1_o[11:8] !== 4'h0) begin failures++; $display("FAIL blank_err nibble2 got=%h want=0", val_1_o[11:8]); end
        for (int i = 0; i < 8; i++) show(i, tbl[4'(i + 6)], 30);
        drain();
        checks += 2;
        if (frame_err_o !== 1'b0) begin failures++; $display("FAIL blank_err clean_frame_err got=%b want=0", frame_err_o); end
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL blank_err frame_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL blank_err frame got=%h want=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_two_lows();
        logic [32:0] o, e;
        for (int i = 0; i < 4; i++) show(i, tbl[4'(i + 1)], 25);
        an_i  = 8'hFC;
        seg_i = tbl[4'hF];
        repeat (100) @(posedge clk);
        #1;
        for (int i = 4; i < 8; i++) show(i, tbl[4'(i + 1)], 25);
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL two_lows frame_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL two_lows frame got=%h want=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_overwrite();
        logic [32:0] o, e;
        show(0, tbl[4'h5], 25);
        for (int i = 1; i < 4; i++) show(i, tbl[4'(i)], 25);
        show(0, tbl[4'h9], 25);
        for (int i = 4; i < 8; i++) show(i, tbl[4'(i)], 25);
        drain();
        checks += 2;
        if (val_1_o[3:0] !== 4'h9) begin failures++; $display("FAIL overwrite nibble0 got=%h want=9", val_1_o[3:0]); end
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL overwrite frame_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL overwrite frame got=%h want=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_scans();
        int          order [8];
        int          j, t;
        logic [32:0] o, e;
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 8; i++) order[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
            for (int i = 0; i < 8; i++) begin
                show(order[i], rand_seg(),
                     ($urandom_range(0, 99) < 85) ? $urandom_range(LONG_MIN, 60) : $urandom_range(3, 10));
            end
        end
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL random frame_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL random frame got=%h want=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
        if (m_have) begin
            checks += 2;
            if ({frame_err_o, val_2_o, val_1_o} !== m_last) begin failures++; $display("FAIL random held_outputs got=%h want=%h", {frame_err_o, val_2_o, val_1_o}, m_last); end
            if (frame_valid_o !== 1'b0) begin failures++; $display("FAIL random idle_valid got=%b want=0", frame_valid_o); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [32:0] o, e;
        for (int i = 0; i < 5; i++) show(i, tbl[4'(i + 10)], 25);
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL reset_mid partial_frames got=%0d want=0", obs_q.size()); end
        #2;
        rst = 1'b1;
        #1;
        checks += 4;
        if (val_1_o !== 16'h0) begin failures++; $display("FAIL reset_mid val_1_o got=%h want=0000", val_1_o); end
        if (val_2_o !== 16'h0) begin failures++; $display("FAIL reset_mid val_2_o got=%h want=0000", val_2_o); end
        if (frame_valid_o !== 1'b0) begin failures++; $display("FAIL reset_mid frame_valid_o got=%b want=0", frame_valid_o); end
        if (frame_err_o !== 1'b0) begin failures++; $display("FAIL reset_mid frame_err_o got=%b want=0", frame_err_o); end
        m_clear();
        m_have = 1'b0;
        obs_q.delete(); exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 5; i < 8; i++) show(i, tbl[4'(i)], 25);
        drain();
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL reset_mid stale_frames got=%0d want=0", obs_q.size()); end
        for (int i = 0; i < 5; i++) show(i, tbl[4'(i)], 25);
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL reset_mid frame_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL reset_mid frame got=%h want=%h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic_scan();
        test_short_dwell();
        test_blank_err();
        test_two_lows();
        test_overwrite();
        test_random_scans();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
